gamma_cycle_sequencer: RTL and testbench
========================================

// Module: gamma_cycle_sequencer
// PURPOSE
// - Sequences a bank of N exclusive_min lanes through gamma cycles:
//   clear the lanes, arm their SR latches, open a compute window, then report results.
// - Records each lane's first output rising edge as a spike time.
// - Sits between the temporal datapath and the downstream column/WTA logic.
// - Sole driver of the lane clear (dp_rst) and lane set (dp_set) strobes.
// PARAMETERS
// - N_LANES            8   number of exclusive_min lanes sequenced
// - GAMMA_CYCLE_WIDTH  16  maximum compute window in aclk cycles; TW = $clog2(GAMMA_CYCLE_WIDTH)+1
// - CLEAR_CYCLES       2   aclk cycles dp_rst is held high per gamma cycle (>=1)
// - SYNC_STAGES        2   synchroniser depth on lane_q (>=2)
// PORTS
// - aclk       in   1          clock
// - grst_n     in   1          asynchronous active-low reset
// - start      in   1          level; gamma cycles run back-to-back while high
// - cfg_window in   TW         compute-window length in aclk cycles; sampled in ARM
// - lane_q     in   N_LANES    exclusive_min q outputs
// - dp_rst     out  1          active-high clear to lanes/counters
// - dp_set     out  1          one-cycle SR-latch set pulse to lanes
// - busy       out  1          high in every state except IDLE
// - res_valid  out  1          result available
// - res_ready  in   1          downstream accepts result
// - res_time   out  N_LANES*TW per-lane spike time, lane i at [i*TW +: TW]
// - res_fired  out  N_LANES    lane produced an edge inside the window
// BEHAVIOUR
// - Reset (grst_n low, async): state=IDLE, dp_rst=1, dp_set=0, busy=0, res_valid=0,
//   res_time=all-ones, res_fired=0, synchronisers cleared. Reset mid-operation aborts the cycle; no result.
// - FSM states: IDLE, CLEAR, ARM, RUN, REPORT.
// - IDLE: dp_rst=1. start=1 -> CLEAR.
// - CLEAR: dp_rst=1 for exactly CLEAR_CYCLES cycles -> ARM.
// - ARM: one cycle; dp_rst=0, dp_set=1. Latch win = max(cfg_window,1), clamped to GAMMA_CYCLE_WIDTH.
//   Clear the capture regs and edge-detect history (prev=0) -> RUN.
// - RUN: t counts 0..win-1, one per cycle.
//   - Rising edge on synchronised lane_q[i] (prev=0, cur=1) with res_fired[i]=0: res_time[i]<=t, res_fired[i]<=1.
//   - Later edges on that lane are ignored.
//   - No latency compensation; the recorded time includes SYNC_STAGES delay.
//   - Edge on the cycle t=win-1 is captured. Sync'd q already high at t=0 records 0.
//   - At t=win-1 -> REPORT.
// - REPORT: dp_rst=1, res_valid=1. res_time/res_fired stable while res_valid.
//   - Unfired lanes report all-ones (NO_SPIKE).
//   - valid&ready: res_valid<=0 next cycle; start=1 -> CLEAR, else -> IDLE.
//   - res_ready low: hold indefinitely (backpressure stalls the gamma clock).
// - start dropping mid-cycle: the current cycle completes through REPORT, then -> IDLE.
// - Cycle period with ready tied high: CLEAR_CYCLES + 1 + win + 1.
// - cfg_window changes outside ARM have no effect on the running cycle.
// - All outputs are registered.
// STRUCTURE
// - Package tnn_seq_pkg:
//   - gcs_state_t enum {IDLE,CLEAR,ARM,RUN,REPORT}
//   - function NO_SPIKE(tw) returning all-ones
// - Sub-module sync_edge_det:
//   - SYNC_STAGES flop synchroniser plus rising-edge detector
//   - clear input reloads prev=0
//   - instantiated once per lane
// - Top: FSM, clear/window counters, per-lane capture registers.
// TESTING
// - Reset: grst_n low mid-RUN -> next cycle busy=0, dp_rst=1, res_valid=0, res_time all-ones.
// - N=8, window 10, lanes 0..7 rise at RUN t=0..7 (post-sync) -> res_time={7..0}, res_fired=8'hFF.
// - Window 4, lane 3 rises at t=3, lane 5 at t=4, others silent
//   -> res_fired=8'h08, lane3=3, others NO_SPIKE.
// - Lane 2 toggles high/low/high within RUN -> only first edge time stored.
// - res_ready low 20 cycles in REPORT -> res_valid and data held; no dp_set pulse until the handshake.
// - start dropped during RUN; cfg_window=0 -> cycle completes, reports, IDLE; win treated as 1.

Source files
------------

// File: rtl/tnn_seq_pkg.sv
// tnn_seq_pkg: shared types and helpers for the gamma cycle sequencer
package tnn_seq_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, ARM, RUN, REPORT} gcs_state_t;
  function automatic logic [31:0] NO_SPIKE(input int tw);
    logic [31:0] m;
    m = '1;
    return m >> (32 - tw);
  endfunction
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchroniser with a clearable rising-edge detector
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic d,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      prev <= clr ? 1'b0 : sync[SYNC_STAGES-1];
    end
  assign rise = sync[SYNC_STAGES-1] & ~prev;
endmodule

// File: rtl/gamma_cycle_sequencer.sv
// gamma_cycle_sequencer: drives lane clear/set strobes and records each lane's
// first spike time inside a configurable compute window
module gamma_cycle_sequencer
  import tnn_seq_pkg::*;
#(
  parameter int N_LANES           = 8,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int CLEAR_CYCLES      = 2,
  parameter int SYNC_STAGES       = 2,
  localparam int TW = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
  input  logic                  aclk,
  input  logic                  grst_n,
  input  logic                  start,
  input  logic [TW-1:0]         cfg_window,
  input  logic [N_LANES-1:0]    lane_q,
  output logic                  dp_rst,
  output logic                  dp_set,
  output logic                  busy,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [N_LANES*TW-1:0] res_time,
  output logic [N_LANES-1:0]    res_fired
);
  localparam logic [TW-1:0] NS = TW'(NO_SPIKE(TW));
  gcs_state_t state, next;
  logic [TW-1:0] cnt, win, win_next;
  logic [N_LANES-1:0] rise;
  logic last_clr, last_run;
  assign last_clr = cnt == TW'(CLEAR_CYCLES - 1);
  assign last_run = cnt == win - TW'(1);
  assign win_next = cfg_window == '0 ? TW'(1)
                  : cfg_window > TW'(GAMMA_CYCLE_WIDTH) ? TW'(GAMMA_CYCLE_WIDTH) : cfg_window;
  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sed (
      .clk(aclk), .rst_n(grst_n), .clr(state == ARM), .d(lane_q[i]), .rise(rise[i])
    );
  end
  always_comb
    next = state == IDLE  ? (start ? CLEAR : IDLE)
         : state == CLEAR ? (last_clr ? ARM : CLEAR)
         : state == ARM   ? RUN
         : state == RUN   ? (last_run ? REPORT : RUN)
         : !res_ready     ? REPORT
         : start          ? CLEAR : IDLE;
  always_ff @(posedge aclk or negedge grst_n)
    if (!grst_n) state <= IDLE;
    else state <= next;
  // Strobes are registered from next state so they line up with the state register.
  always_ff @(posedge aclk or negedge grst_n)
    if (!grst_n) begin
      cnt       <= '0;
      win       <= TW'(1);
      dp_rst    <= 1'b1;
      dp_set    <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_time  <= {N_LANES{NS}};
      res_fired <= '0;
    end else begin
      cnt       <= next != state ? '0 : cnt + TW'(1);
      dp_rst    <= next == IDLE || next == CLEAR || next == REPORT;
      dp_set    <= next == ARM;
      busy      <= next != IDLE;
      res_valid <= next == REPORT;
      if (state == ARM) begin
        win       <= win_next;
        res_time  <= {N_LANES{NS}};
        res_fired <= '0;
      end
      if (state == RUN)
        for (int i = 0; i < N_LANES; i++)
          if (rise[i] && !res_fired[i]) begin
            res_time[i*TW +: TW] <= cnt;
            res_fired[i]         <= 1'b1;
          end
    end
endmodule

// File: tb/tb_gamma_cycle_sequencer.sv
// tb_gamma_cycle_sequencer: directed vectors with hand-computed spike times
module tb_gamma_cycle_sequencer;
  localparam int N = 8, TW = 5;
  logic aclk = 1'b0, grst_n = 1'b0, start = 1'b0, res_ready = 1'b0;
  logic [TW-1:0] cfg_window = '0;
  logic [N-1:0] lane_q = '0;
  logic dp_rst, dp_set, busy, res_valid;
  logic [N*TW-1:0] res_time, exp_t;
  logic [N-1:0] res_fired;
  logic [7:0] pat [0:39];
  int checks = 0, errors = 0;

  always #5 aclk = ~aclk;

  gamma_cycle_sequencer dut (
    .aclk(aclk), .grst_n(grst_n), .start(start), .cfg_window(cfg_window),
    .lane_q(lane_q), .dp_rst(dp_rst), .dp_set(dp_set), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_time(res_time),
    .res_fired(res_fired)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Lane value driven before edge j appears post-sync at RUN t = j-2.
  task automatic gamma(input logic [TW-1:0] w, input int win, input bit keep);
    @(negedge aclk);
    cfg_window = w;
    start = 1'b1;
    lane_q = '0;
    for (int j = 0; j <= 2 + win; j++) begin
      @(posedge aclk);
      @(negedge aclk);
      if (j == 2) check("dp_set_in_arm", dp_set, 1);
      if (j >= 3) begin
        cfg_window = ~w;
        if (!keep) start = 1'b0;
      end
      lane_q = j >= 1 ? pat[j-1] : '0;
    end
    check("valid_before_report", res_valid, 0);
    @(posedge aclk);
    @(negedge aclk);
    check("valid_in_report", res_valid, 1);
    check("dp_rst_in_report", dp_rst, 1);
  endtask

  task automatic finish_report();
    @(negedge aclk);
    res_ready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    check("valid_after_hs", res_valid, 0);
    check("idle_after_hs", busy, 0);
    res_ready = 1'b0;
    lane_q = '0;
  endtask

  initial begin
    for (int t = 0; t < 40; t++) pat[t] = '0;
    repeat (3) @(negedge aclk);
    check("rst_busy", busy, 0);
    check("rst_dp_rst", dp_rst, 1);
    check("rst_dp_set", dp_set, 0);
    check("rst_valid", res_valid, 0);
    check("rst_time", res_time, {N*TW{1'b1}});
    check("rst_fired", res_fired, 0);
    grst_n = 1'b1;

    for (int t = 0; t < 40; t++) for (int i = 0; i < N; i++) pat[t][i] = t >= i;
    gamma(5'd10, 10, 1'b0);
    for (int i = 0; i < N; i++) exp_t[i*TW +: TW] = TW'(i);
    check("a_fired", res_fired, 8'hFF);
    check("a_time", res_time, exp_t);
    finish_report();

    for (int t = 0; t < 40; t++) pat[t] = (t >= 3 ? 8'h08 : 8'h00) | (t >= 4 ? 8'h20 : 8'h00);
    gamma(5'd4, 4, 1'b0);
    exp_t = '1;
    exp_t[3*TW +: TW] = 5'd3;
    check("b_fired", res_fired, 8'h08);
    check("b_time", res_time, exp_t);
    finish_report();

    for (int t = 0; t < 40; t++) pat[t] = (t == 1 || t >= 4) ? 8'h04 : 8'h00;
    gamma(5'd8, 8, 1'b0);
    exp_t = '1;
    exp_t[2*TW +: TW] = 5'd1;
    check("c_fired", res_fired, 8'h04);
    check("c_time", res_time, exp_t);
    finish_report();

    for (int t = 0; t < 40; t++) pat[t] = 8'h01 | (t >= 15 ? 8'h80 : 8'h00) | (t >= 16 ? 8'h40 : 8'h00);
    gamma(5'd31, 16, 1'b0);
    exp_t = '1;
    exp_t[0 +: TW] = 5'd0;
    exp_t[7*TW +: TW] = 5'd15;
    check("clamp_fired", res_fired, 8'h81);
    check("clamp_time", res_time, exp_t);
    finish_report();

    for (int t = 0; t < 40; t++) pat[t] = t >= 2 ? 8'h02 : 8'h00;
    gamma(5'd6, 6, 1'b1);
    exp_t = '1;
    exp_t[1*TW +: TW] = 5'd2;
    for (int k = 0; k < 20; k++) begin
      @(negedge aclk);
      check("bp_valid", res_valid, 1);
      check("bp_no_set", dp_set, 0);
      check("bp_fired", res_fired, 8'h02);
      check("bp_time", res_time, exp_t);
    end
    res_ready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    check("bp_valid_drop", res_valid, 0);
    check("bp_clear_rst", dp_rst, 1);
    check("bp_clear_busy", busy, 1);
    check("bp_clear_set", dp_set, 0);
    res_ready = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check("bp_clear2_set", dp_set, 0);
    @(posedge aclk);
    @(negedge aclk);
    check("bp_arm_set", dp_set, 1);
    start = 1'b0;
    for (int k = 0; k < 40 && !res_valid; k++) @(negedge aclk);
    check("bp_second_report", res_valid, 1);
    finish_report();

    for (int t = 0; t < 40; t++) pat[t] = 8'h01;
    gamma(5'd0, 1, 1'b0);
    exp_t = '1;
    exp_t[0 +: TW] = 5'd0;
    check("w0_fired", res_fired, 8'h01);
    check("w0_time", res_time, exp_t);
    finish_report();

    @(negedge aclk);
    start = 1'b1;
    cfg_window = 5'd10;
    lane_q = 8'hFF;
    repeat (6) @(negedge aclk);
    check("mid_fired", res_fired, 8'hFF);
    start = 1'b0;
    grst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_dp_rst", dp_rst, 1);
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_time", res_time, {N*TW{1'b1}});
    check("mid_rst_fired", res_fired, 0);
    @(negedge aclk);
    grst_n = 1'b1;
    lane_q = '0;
    @(negedge aclk);
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", res_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
